fb_frame_writer: RTL and testbench



---
 rtl/fb_frame_writer.sv | 186 ++++++++++++++++++
 tb/tb_fb_frame_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_frame_writer.sv
// Frame-buffer write producer: packs PIX_PER_WORD pixels per word and strobes
// FRAME_WORDS words per frame. Define FB_FRAME_WR_TIMEOUT_EN to abort stalled writes.
module fb_frame_writer #(
  parameter int PIX_WIDTH    = 8,
  parameter int PIX_PER_WORD = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int FRAME_WORDS  = 500,
  parameter int CNT_WIDTH    = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  pix_ready,
  input  logic                  fb_wr_rdy,
  output logic                  fb_wr_en_l,
  output logic [DATA_WIDTH-1:0] fb_data,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

  state_t                state_reg, state_next;
  logic [LANE_W-1:0]     lane_reg, lane_next, load_lane;
  logic                  pix_load, pack_clear;
  logic                  wr_en_l_reg, wr_en_l_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [PIX_WIDTH-1:0]  lane_data [PIX_PER_WORD];
  logic                  pix_acc, word_acc, stall_expire;

  assign pix_ready  = !reset && (state_reg == IDLE || state_reg == PACK);
  assign pix_acc    = pix_valid && pix_ready;
  assign word_acc   = !wr_en_l_reg && fb_wr_rdy;
  assign fb_wr_en_l = wr_en_l_reg;
  assign frame_busy = busy_reg;
  assign frame_done = done_reg;
  assign frame_err  = err_reg;
  assign word_cnt   = cnt_reg;

`ifdef FB_FRAME_WR_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_reg, stall_next;

  // Counter sits at zero outside WRITE, so every WRITE entry starts clean.
  always_comb begin
    stall_next   = stall_reg;
    stall_expire = 1'b0;
    if (state_reg != WRITE) begin
      stall_next = '0;
    end else if (!fb_wr_rdy) begin
      stall_next = stall_reg + 1'b1;
      if (stall_reg == STALL_W'(TIMEOUT - 1))
        stall_expire = 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset) stall_reg <= '0;
    else       stall_reg <= stall_next;
  end
`else
  assign stall_expire = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    load_lane  = lane_reg;
    pix_load   = 1'b0;
    pack_clear = 1'b0;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pix_acc && pix_sof) begin
          pix_load   = 1'b1;
          pack_clear = 1'b1;
          load_lane  = '0;
          busy_next  = 1'b1;
          cnt_next   = '0;
          if (PIX_PER_WORD == 1) begin
            state_next = WRITE;
            lane_next  = '0;
          end else begin
            state_next = PACK;
            lane_next  = LANE_W'(1);
          end
        end
      end
      PACK: begin
        if (pix_acc) begin
          pix_load = 1'b1;
          if (pix_sof) begin
            // Resync: restart the frame with this pixel as lane 0.
            pack_clear = 1'b1;
            load_lane  = '0;
            cnt_next   = '0;
            err_next   = 1'b1;
            if (PIX_PER_WORD == 1) begin
              state_next = WRITE;
              lane_next  = '0;
            end else begin
              state_next = PACK;
              lane_next  = LANE_W'(1);
            end
          end else if (lane_reg == LAST_LANE) begin
            lane_next  = '0;
            state_next = WRITE;
          end else begin
            lane_next = lane_reg + 1'b1;
          end
        end
      end
      WRITE: begin
        if (word_acc) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_next == LAST_CNT) begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            state_next = PACK;
          end
        end else if (stall_expire) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          err_next   = 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    wr_en_l_next = (state_next != WRITE);
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      lane_reg    <= '0;
      wr_en_l_reg <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      lane_reg    <= lane_next;
      wr_en_l_reg <= wr_en_l_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      cnt_reg     <= cnt_next;
    end
  end

  // One register per lane; an SOF clears the lanes it does not load.
  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
      always_ff @(posedge wr_clk) begin
        if (reset)
          lane_data[gi] <= '0;
        else if (pix_load && load_lane == LANE_W'(gi))
          lane_data[gi] <= pix_data;
        else if (pack_clear)
          lane_data[gi] <= '0;
      end
      assign fb_data[gi*PIX_WIDTH +: PIX_WIDTH] = lane_data[gi];
    end
  endgenerate

endmodule

// File: tb/tb_fb_frame_writer.sv
// Directed bench for fb_frame_writer with FRAME_WORDS=2, four 8-bit pixels per word.
// Build with FB_FRAME_WR_TIMEOUT_EN defined to also exercise the stall abort.
module tb_fb_frame_writer;

  logic        wr_clk = 1'b0;
  logic        reset;
  logic        pix_valid, pix_sof;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        fb_wr_rdy;
  logic        fb_wr_en_l;
  logic [31:0] fb_data;
  logic        frame_busy, frame_done, frame_err;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] words[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int n_before;

`ifdef FB_FRAME_WR_TIMEOUT_EN
  localparam int STALL = 3;
`else
  localparam int STALL = 5;
`endif

  fb_frame_writer #(
    .PIX_WIDTH(8), .PIX_PER_WORD(4), .DATA_WIDTH(32),
    .FRAME_WORDS(2), .CNT_WIDTH(16), .TIMEOUT(4)
  ) dut (
    .wr_clk(wr_clk), .reset(reset),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .pix_ready(pix_ready), .fb_wr_rdy(fb_wr_rdy), .fb_wr_en_l(fb_wr_en_l),
    .fb_data(fb_data), .frame_busy(frame_busy), .frame_done(frame_done),
    .frame_err(frame_err), .word_cnt(word_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Word acceptance and pulse monitor, sampled at the active edge.
  always @(posedge wr_clk) begin
    if (reset === 1'b0) begin
      if (fb_wr_en_l === 1'b0 && fb_wr_rdy === 1'b1) begin
        words.push_back(fb_data);
        $display("word %0d accepted: 0x%08h", words.size() - 1, fb_data);
      end
      if (frame_done === 1'b1) done_cnt++;
      if (frame_err === 1'b1) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel at the falling edge and hold it until accepted.
  task automatic push(input logic [7:0] d, input logic s);
    int n = 0;
    pix_data  = d;
    pix_sof   = s;
    pix_valid = 1'b1;
    while (pix_ready !== 1'b1 && n < 50) begin
      @(negedge wr_clk);
      n++;
    end
    check("push_ready", {31'b0, pix_ready}, 32'd1);
    @(negedge wr_clk);
    $display("pixel 0x%02h sof=%0d accepted", d, s);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'h00; fb_wr_rdy = 1'b1;
    repeat (3) @(negedge wr_clk);
    check("rst_ready",   {31'b0, pix_ready},  32'd0);
    check("rst_wr_en_l", {31'b0, fb_wr_en_l}, 32'd1);
    check("rst_data",    fb_data,             32'd0);
    check("rst_busy",    {31'b0, frame_busy}, 32'd0);
    check("rst_done",    {31'b0, frame_done}, 32'd0);
    check("rst_err",     {31'b0, frame_err},  32'd0);
    check("rst_cnt",     {16'b0, word_cnt},   32'd0);
    reset = 1'b0;
    @(negedge wr_clk);
    check("post_rst_ready", {31'b0, pix_ready},  32'd1);
    check("post_rst_wr_en", {31'b0, fb_wr_en_l}, 32'd1);

    // Frame A: two words, free-flowing write port.
    push(8'h11, 1'b1);
    check("a_busy", {31'b0, frame_busy}, 32'd1);
    check("a_cnt0", {16'b0, word_cnt},   32'd0);
    push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b0);
    check("a_strobe",   {31'b0, fb_wr_en_l}, 32'd0);
    check("a_data0",    fb_data,             32'h44332211);
    check("a_ready_wr", {31'b0, pix_ready},  32'd0);
    push(8'h55, 1'b0);
    check("a_cnt1", {16'b0, word_cnt}, 32'd1);
    push(8'h66, 1'b0); push(8'h77, 1'b0); push(8'h88, 1'b0);
    @(negedge wr_clk);
    check("a_done",      {31'b0, frame_done}, 32'd1);
    check("a_busy_fall", {31'b0, frame_busy}, 32'd0);
    check("a_cnt2",      {16'b0, word_cnt},   32'd2);
    @(negedge wr_clk);
    check("a_done_pulse", {31'b0, frame_done}, 32'd0);
    check("a_cnt_hold",   {16'b0, word_cnt},   32'd2);
    check("a_nwords",     words.size(),        32'd2);
    check("a_w0",         words[0],            32'h44332211);
    check("a_w1",         words[1],            32'h88776655);
    check("a_ndone",      done_cnt,            32'd1);

    // Frame B: non-SOF pixels in IDLE are dropped.
    push(8'hAA, 1'b0); push(8'hBB, 1'b0);
    check("b_idle_busy", {31'b0, frame_busy}, 32'd0);
    push(8'h01, 1'b1); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    check("b_data0", fb_data, 32'h04030201);
    push(8'h05, 1'b0); push(8'h06, 1'b0); push(8'h07, 1'b0); push(8'h08, 1'b0);
    repeat (2) @(negedge wr_clk);
    check("b_w0",    words[2], 32'h04030201);
    check("b_w1",    words[3], 32'h08070605);
    check("b_ndone", done_cnt, 32'd2);

    // Frame C: frame buffer stalls the first word.
    fb_wr_rdy = 1'b0;
    push(8'hC1, 1'b1); push(8'hC2, 1'b0); push(8'hC3, 1'b0); push(8'hC4, 1'b0);
    n_before = words.size();
    for (int i = 0; i < STALL; i++) begin
      check("c_stall_strobe", {31'b0, fb_wr_en_l}, 32'd0);
      check("c_stall_data",   fb_data,             32'hC4C3C2C1);
      check("c_stall_ready",  {31'b0, pix_ready},  32'd0);
      @(negedge wr_clk);
    end
    check("c_no_accept", words.size(), n_before);
    fb_wr_rdy = 1'b1;
    @(negedge wr_clk);
    check("c_release",  {31'b0, fb_wr_en_l}, 32'd1);
    check("c_cnt1",     {16'b0, word_cnt},   32'd1);
    check("c_once",     words.size(),        n_before + 1);
    check("c_w0",       words[n_before],     32'hC4C3C2C1);
    push(8'hD1, 1'b0); push(8'hD2, 1'b0); push(8'hD3, 1'b0); push(8'hD4, 1'b0);
    repeat (2) @(negedge wr_clk);
    check("c_w1",    words[5], 32'hD4D3D2D1);
    check("c_ndone", done_cnt, 32'd3);

    // Frame E/F: SOF two pixels into the second word resyncs the frame.
    push(8'hE1, 1'b1); push(8'hE2, 1'b0); push(8'hE3, 1'b0); push(8'hE4, 1'b0);
    push(8'hE5, 1'b0); push(8'hE6, 1'b0);
    check("e_cnt1", {16'b0, word_cnt}, 32'd1);
    push(8'hF1, 1'b1);
    check("f_err",  {31'b0, frame_err},  32'd1);
    check("f_cnt0", {16'b0, word_cnt},   32'd0);
    check("f_busy", {31'b0, frame_busy}, 32'd1);
    push(8'hF2, 1'b0);
    check("f_err_pulse", {31'b0, frame_err}, 32'd0);
    push(8'hF3, 1'b0); push(8'hF4, 1'b0);
    check("f_data0", fb_data, 32'hF4F3F2F1);
    push(8'hF5, 1'b0); push(8'hF6, 1'b0); push(8'hF7, 1'b0); push(8'hF8, 1'b0);
    repeat (2) @(negedge wr_clk);
    check("f_nwords", words.size(), 32'd9);
    check("e_w0",     words[6],     32'hE4E3E2E1);
    check("f_w0",     words[7],     32'hF4F3F2F1);
    check("f_w1",     words[8],     32'hF8F7F6F5);
    check("f_nerr",   err_cnt,      32'd1);
    check("f_ndone",  done_cnt,     32'd4);

`ifdef FB_FRAME_WR_TIMEOUT_EN
    // Frame G: write port never ready, abort after four stalled cycles.
    fb_wr_rdy = 1'b0;
    push(8'h71, 1'b1); push(8'h72, 1'b0); push(8'h73, 1'b0); push(8'h74, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("g_strobe_low", {31'b0, fb_wr_en_l}, 32'd0);
      @(negedge wr_clk);
    end
    check("g_abort_strobe", {31'b0, fb_wr_en_l}, 32'd1);
    check("g_abort_busy",   {31'b0, frame_busy}, 32'd0);
    check("g_abort_err",    {31'b0, frame_err},  32'd1);
    @(negedge wr_clk);
    check("g_err_pulse",  {31'b0, frame_err},  32'd0);
    check("g_idle_ready", {31'b0, pix_ready},  32'd1);
    check("g_no_done",    done_cnt,            32'd4);
    check("g_nerr",       err_cnt,             32'd2);
    check("g_nwords",     words.size(),        32'd9);
    fb_wr_rdy = 1'b1;
`endif

    // Reset while the strobe is asserted.
    fb_wr_rdy = 1'b0;
    push(8'h91, 1'b1); push(8'h92, 1'b0); push(8'h93, 1'b0); push(8'h94, 1'b0);
    check("r_strobe_low", {31'b0, fb_wr_en_l}, 32'd0);
    reset = 1'b1;
    @(negedge wr_clk);
    check("r_strobe_rel", {31'b0, fb_wr_en_l}, 32'd1);
    check("r_busy",       {31'b0, frame_busy}, 32'd0);
    check("r_cnt",        {16'b0, word_cnt},   32'd0);
    check("r_ready",      {31'b0, pix_ready},  32'd0);
    reset = 1'b0;
    fb_wr_rdy = 1'b1;
    repeat (3) @(negedge wr_clk);
    check("r_no_done",  done_cnt,            32'd4);
    check("r_no_word",  words.size(),        32'd9);
    check("r_idle_str", {31'b0, fb_wr_en_l}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
